load_use_hazard_unit: RTL and testbench

- Parametrised load-use hazard detector and stall sequencer for the pipelined OTTER core.
- Compares the ID-stage source registers against a load in EX.
- Freezes PC and IF/ID and injects an EX bubble for a configurable number of cycles.
- Gives taken-branch flushes priority over stalls and keeps a saturating stall-event counter for performance analysis.

---
 rtl/load_use_hazard_unit.sv | 86 ++++++++
 tb/tb_load_use_hazard_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit: load-use hazard detector and stall sequencer for the pipelined OTTER core.
// A stall lasts LOAD_LATENCY cycles: the detect cycle plus LOAD_LATENCY-1 cycles in STALL.
module load_use_hazard_unit #(
    parameter int LOAD_LATENCY = 2,
    parameter int CNT_W        = 3,
    parameter int REG_W        = 5,
    parameter int EVT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_valid,
    input  logic [6:0]       ex_opcode,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             stall_active,
    output logic [CNT_W-1:0] count,
    output logic [REG_W-1:0] hazard_rd,
    output logic [EVT_W-1:0] stall_events
);
    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [6:0]       OP_LOAD = 7'b0000011;
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LOAD_LATENCY - 1);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    generate
        if (LOAD_LATENCY < 1 || LOAD_LATENCY >= (1 << CNT_W)) begin : g_bad_latency
            $error("load_use_hazard_unit: LOAD_LATENCY out of range for CNT_W");
        end
    endgenerate

    state_t           state, state_nx;
    logic [CNT_W-1:0] count_nx;
    logic [REG_W-1:0] hazard_rd_nx;
    logic [EVT_W-1:0] stall_events_nx;
    logic             load_use, start, stall;

    assign load_use = id_valid & ex_valid & (ex_opcode == OP_LOAD) & (ex_rd != '0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    // A taken branch flushes the ID instruction, so its hazard never starts a stall.
    assign start = (state == IDLE) & load_use & ~branch_taken;
    assign stall = (state == STALL) | start;

    assign stall_pc     = stall;
    assign stall_ifid   = stall;
    assign bubble_idex  = stall;
    assign stall_active = stall;

    always_comb begin
        state_nx        = state;
        count_nx        = count;
        hazard_rd_nx    = hazard_rd;
        stall_events_nx = stall_events;
        if (start) begin
            stall_events_nx = (stall_events == EVT_MAX) ? stall_events : stall_events + 1'b1;
            hazard_rd_nx    = ex_rd;
            state_nx        = (LOAD_LATENCY == 1) ? IDLE : STALL;
            count_nx        = LAT_M1;
        end else if (state == STALL) begin
            state_nx = (branch_taken || count == CNT_W'(1)) ? IDLE : STALL;
            count_nx = (branch_taken || count == CNT_W'(1)) ? '0 : count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            count        <= '0;
            hazard_rd    <= '0;
            stall_events <= '0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            hazard_rd    <= hazard_rd_nx;
            stall_events <= stall_events_nx;
        end
    end
endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb_load_use_hazard_unit: directed checks of three hazard-unit configurations driven by shared stimulus.
// u2: LOAD_LATENCY=2, u4: LOAD_LATENCY=4, u1: LOAD_LATENCY=1 with a 2-bit event counter.
module tb_load_use_hazard_unit;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] RT = 7'b0110011;

    logic       CLK = 0, RST_N = 0;
    logic       id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, ex_valid = 0, branch_taken = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic [6:0] ex_opcode = 0;
    logic [3:0] st2, st4, st1;
    logic [2:0] c2, c4, c1;
    logic [4:0] h2, h4, h1;
    logic [15:0] e2, e4;
    logic [1:0] e1;
    int tests = 0, fails = 0;

    always #5 CLK = ~CLK;

    load_use_hazard_unit #(.LOAD_LATENCY(2)) u2 (
        .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .stall_pc(st2[3]), .stall_ifid(st2[2]), .bubble_idex(st2[1]), .stall_active(st2[0]),
        .count(c2), .hazard_rd(h2), .stall_events(e2));
    load_use_hazard_unit #(.LOAD_LATENCY(4)) u4 (
        .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .stall_pc(st4[3]), .stall_ifid(st4[2]), .bubble_idex(st4[1]), .stall_active(st4[0]),
        .count(c4), .hazard_rd(h4), .stall_events(e4));
    load_use_hazard_unit #(.LOAD_LATENCY(1), .EVT_W(2)) u1 (
        .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .stall_pc(st1[3]), .stall_ifid(st1[2]), .bubble_idex(st1[1]), .stall_active(st1[0]),
        .count(c1), .hazard_rd(h1), .stall_events(e1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic haz(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [6:0] op, input logic [4:0] rd, input logic br);
        id_valid = 1; ex_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_opcode = op; ex_rd = rd; branch_taken = br;
        #1;
    endtask

    task automatic quiet;
        ex_valid = 0; branch_taken = 0;
        #1;
    endtask

    task automatic cyc(input string tag, input logic s2, input int k2, input logic s4, input int k4, input logic s1);
        check({tag, ".st2"}, 32'(st2), 32'({4{s2}}));
        check({tag, ".cnt2"}, 32'(c2), k2);
        check({tag, ".st4"}, 32'(st4), 32'({4{s4}}));
        check({tag, ".cnt4"}, 32'(c4), k4);
        check({tag, ".st1"}, 32'(st1), 32'({4{s1}}));
        check({tag, ".cnt1"}, 32'(c1), 0);
    endtask

    // Expects a hazard already applied in the current (detect) cycle; it is withdrawn after one cycle.
    task automatic full(input string tag);
        cyc({tag, "c0"}, 1, 0, 1, 0, 1);
        tick; quiet;
        cyc({tag, "c1"}, 1, 1, 1, 3, 0);
        tick;
        cyc({tag, "c2"}, 0, 0, 1, 2, 0);
        tick;
        cyc({tag, "c3"}, 0, 0, 1, 1, 0);
        tick;
        cyc({tag, "c4"}, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) tick;
        cyc("rst", 0, 0, 0, 0, 0);
        check("rst.hrd", 32'(h2), 0);
        check("rst.evt", 32'(e2), 0);
        RST_N = 1;
        tick;

        haz(5, 1, 0, 0, LD, 5, 0);
        full("t1");
        check("t1.hrd2", 32'(h2), 5);
        check("t1.evt2", 32'(e2), 1);
        check("t1.evt1", 32'(e1), 1);

        haz(0, 1, 0, 0, LD, 0, 0);
        cyc("t2x0", 0, 0, 0, 0, 0);
        haz(5, 1, 0, 0, RT, 5, 0);
        cyc("t2rt", 0, 0, 0, 0, 0);
        tick; quiet;
        cyc("t2q", 0, 0, 0, 0, 0);
        check("t2.evt2", 32'(e2), 1);

        haz(3, 1, 7, 0, LD, 7, 0);
        cyc("t3unused", 0, 0, 0, 0, 0);
        haz(3, 1, 7, 1, LD, 7, 0);
        full("t3");
        check("t3.hrd4", 32'(h4), 7);
        check("t3.evt2", 32'(e2), 2);
        check("t3.evt1", 32'(e1), 2);

        haz(5, 1, 0, 0, LD, 5, 1);
        cyc("t4flush", 0, 0, 0, 0, 0);
        tick; quiet;
        cyc("t4after", 0, 0, 0, 0, 0);
        check("t4.evt2", 32'(e2), 2);
        check("t4.hrd2", 32'(h2), 7);

        haz(6, 1, 0, 0, LD, 6, 0);
        cyc("t4bc0", 1, 0, 1, 0, 1);
        tick; quiet;
        cyc("t4bc1", 1, 1, 1, 3, 0);
        tick;
        branch_taken = 1;
        #1;
        cyc("t4bbr", 0, 0, 1, 2, 0);
        tick; quiet;
        cyc("t4babort", 0, 0, 0, 0, 0);
        check("t4b.evt4", 32'(e4), 3);
        check("t4b.evt1", 32'(e1), 3);

        haz(9, 1, 0, 0, LD, 9, 0);
        tick; quiet;
        tick;
        check("t5.cnt4pre", 32'(c4), 2);
        RST_N = 0;
        #1;
        cyc("t5async", 0, 0, 0, 0, 0);
        check("t5.hrd4", 32'(h4), 0);
        check("t5.evt4", 32'(e4), 0);
        check("t5.evt1", 32'(e1), 0);
        RST_N = 1;
        tick;
        haz(9, 1, 0, 0, LD, 9, 0);
        full("t5");
        check("t5.hrd4b", 32'(h4), 9);
        check("t5.evt4b", 32'(e4), 1);

        RST_N = 0;
        tick;
        RST_N = 1;
        tick;
        for (int i = 0; i < 5; i++) begin
            haz(5'(i + 10), 1, 0, 0, LD, 5'(i + 10), 0);
            check("t6.st1on", 32'(st1), 15);
            check("t6.cnt1on", 32'(c1), 0);
            tick; quiet;
            check("t6.st1off", 32'(st1), 0);
            check("t6.cnt1off", 32'(c1), 0);
            check("t6.evt1", 32'(e1), (i < 2) ? i + 1 : 3);
            check("t6.hrd1", 32'(h1), i + 10);
            repeat (3) tick;
        end
        check("t6.evt2", 32'(e2), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
